processor_scheduler: RTL and testbench

Parametrised processor scheduler and shared-bus multiplexer for N processors. Exactly one processor is enabled at a time. The enabled processor hands control to any other processor by requesting a switch with a target ID. The block inserts a quiet handover gap between processors, supervises the active processor with a watchdog, and latches a sticky fault with cause and culprit. It sits at the top level between the processors and the memory, GPU and interrupt controllers, and drives the LED and buzzer.

---
 rtl/processor_scheduler.sv | 211 +++++++++++++++++++++
 tb/tb_processor_scheduler.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/processor_scheduler.sv
// processor_scheduler
//   Hands a shared memory/GPU/interrupt bus to exactly one of NUM_PROC
//   processors at a time. The owner passes control by requesting a switch
//   to a target ID. Each switch goes through an all-disabled handover gap.
//   The owner is supervised by a watchdog. Any fault is latched stickily
//   with its cause and culprit until reset, and drives the LED and buzzer.
//
// Ports
//   clk_i, rst_i            rising-edge clock, asynchronous active-high reset
//   proc_enable_o           one-hot enable to the owning processor
//   proc_switch_req_i       per-processor switch request
//   proc_switch_target_i    per-processor target ID (slice i = processor i)
//   proc_fatal_i            per-processor fatal error
//   proc_mem_*_i, proc_gpu_draw_i, proc_iack_i, proc_iend_i
//                           per-processor bus controls, address and data
//   mem_*_o, gpu_draw_o, iack_o, iend_o
//                           bus muxed from the owner, zero when nobody owns it
//   active_id_o             current owner
//   error_o, error_code_o, error_id_o
//                           sticky fault flag, cause (1 fatal, 2 bad target,
//                           3 watchdog) and culprit
//   out_led_o, out_buzzer_o fault indicators
module processor_scheduler #(
  parameter int NUM_PROC        = 4,
  parameter int ADDR_W          = 16,
  parameter int DATA_W          = 16,
  parameter int BOOT_ID         = 0,
  parameter int HANDOVER_CYCLES = 1,
  parameter int WDT_CYCLES      = 0,
  parameter int BUZZ_DIV        = 25000000,
  localparam int ID_W           = (NUM_PROC > 2) ? $clog2(NUM_PROC) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  output logic [NUM_PROC-1:0]      proc_enable_o,
  input  logic [NUM_PROC-1:0]      proc_switch_req_i,
  input  logic [NUM_PROC*ID_W-1:0] proc_switch_target_i,
  input  logic [NUM_PROC-1:0]      proc_fatal_i,
  input  logic [NUM_PROC-1:0]      proc_mem_enable_i,
  input  logic [NUM_PROC-1:0]      proc_mem_write_i,
  input  logic [NUM_PROC-1:0]      proc_gpu_draw_i,
  input  logic [NUM_PROC-1:0]      proc_iack_i,
  input  logic [NUM_PROC-1:0]      proc_iend_i,
  input  logic [NUM_PROC*ADDR_W-1:0] proc_mem_addr_i,
  input  logic [NUM_PROC*DATA_W-1:0] proc_mem_dataw_i,
  output logic                     mem_enable_o,
  output logic                     mem_write_o,
  output logic                     gpu_draw_o,
  output logic                     iack_o,
  output logic                     iend_o,
  output logic [ADDR_W-1:0]        mem_addr_o,
  output logic [DATA_W-1:0]        mem_dataw_o,
  output logic [ID_W-1:0]          active_id_o,
  output logic                     error_o,
  output logic [1:0]               error_code_o,
  output logic [ID_W-1:0]          error_id_o,
  output logic                     out_led_o,
  output logic                     out_buzzer_o
);

  localparam int HO_W  = (HANDOVER_CYCLES > 1) ? $clog2(HANDOVER_CYCLES) : 1;
  localparam int WDT_W = (WDT_CYCLES > 0) ? $clog2(WDT_CYCLES + 1) : 1;
  localparam int BUZ_W = (BUZZ_DIV > 1) ? $clog2(BUZZ_DIV) : 1;

  localparam logic [HO_W-1:0]  HO_LAST  = HO_W'(HANDOVER_CYCLES - 1);
  localparam logic [WDT_W-1:0] WDT_LAST = (WDT_CYCLES > 0) ? WDT_W'(WDT_CYCLES - 1) : '0;
  localparam logic [BUZ_W-1:0] BUZ_LAST = BUZ_W'(BUZZ_DIV - 1);

  typedef enum logic [1:0] {BOOT, RUN, HANDOVER, FAULT} state_e;

  state_e            state_q, state_d;
  logic              bootArmed_q, bootArmed_d;
  logic [ID_W-1:0]   activeId_q, activeId_d;
  logic [ID_W-1:0]   pending_q, pending_d;
  logic [HO_W-1:0]   hoCnt_q, hoCnt_d;
  logic [WDT_W-1:0]  wdt_q, wdt_d;
  logic [BUZ_W-1:0]  buzzCnt_q, buzzCnt_d;
  logic              buzzer_q, buzzer_d;
  logic [1:0]        errCode_q, errCode_d;
  logic [ID_W-1:0]   errId_q, errId_d;

  logic              selFatal, selReq, selMemEn, wdtHit, targetInvalid;
  logic [ID_W-1:0]   selTarget;

  // Controls of the current owner; every other processor is ignored.
  always_comb begin
    selFatal      = proc_fatal_i[activeId_q];
    selReq        = proc_switch_req_i[activeId_q];
    selMemEn      = proc_mem_enable_i[activeId_q];
    selTarget     = proc_switch_target_i[int'(activeId_q)*ID_W +: ID_W];
    targetInvalid = (int'(selTarget) >= NUM_PROC);
    // The fault fires on the idle cycle that would bring the counter to
    // WDT_CYCLES, so the error shows exactly WDT_CYCLES cycles after RUN entry.
    wdtHit        = (WDT_CYCLES > 0) && !selMemEn && (wdt_q == WDT_LAST);
  end

  // The first edge after reset release only arms BOOT, so BOOT spans one
  // full cycle and RUN begins after the second edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= BOOT;
      bootArmed_q <= 1'b0;
      activeId_q  <= ID_W'(BOOT_ID);
      pending_q   <= ID_W'(BOOT_ID);
      hoCnt_q     <= '0;
      wdt_q       <= '0;
      buzzCnt_q   <= '0;
      buzzer_q    <= 1'b0;
      errCode_q   <= 2'd0;
      errId_q     <= '0;
    end else begin
      state_q     <= state_d;
      bootArmed_q <= bootArmed_d;
      activeId_q  <= activeId_d;
      pending_q   <= pending_d;
      hoCnt_q     <= hoCnt_d;
      wdt_q       <= wdt_d;
      buzzCnt_q   <= buzzCnt_d;
      buzzer_q    <= buzzer_d;
      errCode_q   <= errCode_d;
      errId_q     <= errId_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bootArmed_d = 1'b1;
    activeId_d  = activeId_q;
    pending_d   = pending_q;
    hoCnt_d     = '0;
    wdt_d       = '0;
    buzzCnt_d   = '0;
    buzzer_d    = buzzer_q;
    errCode_d   = errCode_q;
    errId_d     = errId_q;

    case (state_q)
      BOOT: begin
        if (bootArmed_q) state_d = RUN;
      end
      RUN: begin
        if (!selMemEn && wdt_q != '1) wdt_d = wdt_q + 1'b1;
        if (selFatal) begin
          state_d   = FAULT;
          errCode_d = 2'd1;
          errId_d   = activeId_q;
        end else if (wdtHit) begin
          state_d   = FAULT;
          errCode_d = 2'd3;
          errId_d   = activeId_q;
        end else if (selReq && targetInvalid) begin
          state_d   = FAULT;
          errCode_d = 2'd2;
          errId_d   = activeId_q;
        end else if (selReq && selTarget != activeId_q) begin
          state_d   = HANDOVER;
          pending_d = selTarget;
        end
        // The counter only lives in RUN, so a fresh owner starts from zero.
        if (state_d != RUN) wdt_d = '0;
      end
      HANDOVER: begin
        hoCnt_d = hoCnt_q + 1'b1;
        if (hoCnt_q == HO_LAST) begin
          state_d    = RUN;
          activeId_d = pending_q;
          hoCnt_d    = '0;
        end
      end
      FAULT: begin
        if (buzzCnt_q == BUZ_LAST) begin
          buzzer_d  = ~buzzer_q;
        end else begin
          buzzCnt_d = buzzCnt_q + 1'b1;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  // Enables and the bus are a pure decode of the registered state, giving
  // zero-cycle latency from the owner; everything is quiet outside RUN.
  always_comb begin
    proc_enable_o = '0;
    mem_enable_o  = 1'b0;
    mem_write_o   = 1'b0;
    gpu_draw_o    = 1'b0;
    iack_o        = 1'b0;
    iend_o        = 1'b0;
    mem_addr_o    = '0;
    mem_dataw_o   = '0;
    if (state_q == RUN) begin
      proc_enable_o[activeId_q] = 1'b1;
      mem_enable_o = selMemEn;
      mem_write_o  = proc_mem_write_i[activeId_q];
      gpu_draw_o   = proc_gpu_draw_i[activeId_q];
      iack_o       = proc_iack_i[activeId_q];
      iend_o       = proc_iend_i[activeId_q];
      mem_addr_o   = proc_mem_addr_i[int'(activeId_q)*ADDR_W +: ADDR_W];
      mem_dataw_o  = proc_mem_dataw_i[int'(activeId_q)*DATA_W +: DATA_W];
    end
  end

  assign active_id_o  = activeId_q;
  assign error_o      = (state_q == FAULT);
  assign error_code_o = errCode_q;
  assign error_id_o   = errId_q;
  assign out_led_o    = (state_q == FAULT);
  assign out_buzzer_o = buzzer_q;

endmodule

// File: tb/tb_processor_scheduler.sv
module tb_processor_scheduler;

   localparam int NP = 3;
   localparam int IW = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [NP-1:0] procEnable;
   logic [NP-1:0] procSwitchReq;
   logic [NP*IW-1:0] procSwitchTarget;
   logic [NP-1:0] procFatal;
   logic [NP-1:0] procMemEnable;
   logic [NP-1:0] procMemWrite;
   logic [NP-1:0] procGpuDraw;
   logic [NP-1:0] procIack;
   logic [NP-1:0] procIend;
   logic [NP*16-1:0] procMemAddr;
   logic [NP*16-1:0] procMemDataw;
   logic          memEnable, memWrite, gpuDraw, iack, iend;
   logic [15:0]   memAddr, memDataw;
   logic [IW-1:0] activeId;
   logic          error;
   logic [1:0]    errorCode;
   logic [IW-1:0] errorId;
   logic          outLed, outBuzzer;

   int checks = 0;
   int errors = 0;

   logic [15:0] addrTbl [NP];
   logic [15:0] dataTbl [NP];

   typedef struct {
      logic [2:0]  en;
      logic [1:0]  act;
      logic        err;
      logic [1:0]  code;
      logic [1:0]  eid;
      logic        buzz;
      logic [15:0] addr;
      logic [15:0] data;
      logic        memEn;
      logic        memWr;
      logic        gpu;
   } exp_t;

   exp_t expQ[$];

   processor_scheduler #(
      .NUM_PROC(NP), .ADDR_W(16), .DATA_W(16), .BOOT_ID(0),
      .HANDOVER_CYCLES(2), .WDT_CYCLES(5), .BUZZ_DIV(4)
   ) dut (
      .clk_i(clk), .rst_i(rst),
      .proc_enable_o(procEnable),
      .proc_switch_req_i(procSwitchReq),
      .proc_switch_target_i(procSwitchTarget),
      .proc_fatal_i(procFatal),
      .proc_mem_enable_i(procMemEnable),
      .proc_mem_write_i(procMemWrite),
      .proc_gpu_draw_i(procGpuDraw),
      .proc_iack_i(procIack),
      .proc_iend_i(procIend),
      .proc_mem_addr_i(procMemAddr),
      .proc_mem_dataw_i(procMemDataw),
      .mem_enable_o(memEnable), .mem_write_o(memWrite), .gpu_draw_o(gpuDraw),
      .iack_o(iack), .iend_o(iend),
      .mem_addr_o(memAddr), .mem_dataw_o(memDataw),
      .active_id_o(activeId),
      .error_o(error), .error_code_o(errorCode), .error_id_o(errorId),
      .out_led_o(outLed), .out_buzzer_o(outBuzzer)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   // Hard time limit so a stuck run still ends with a report
   initial begin
      #1000000;
      $display("[TB] FAIL timeout: simulation did not finish, observed running expected finished");
      $fatal(1, "[TB] timeout");
   end

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Push the expected observable state; bus expectations come from what the
   // named owner is currently driving, or zero when nobody should own the bus.
   task automatic applyStimulus(input logic [2:0] en, input logic [1:0] act,
                                input logic err, input logic [1:0] code,
                                input logic [1:0] eid, input logic buzz);
      exp_t e;
      logic busOn;
      busOn   = (en != 3'b000);
      e.en    = en;
      e.act   = act;
      e.err   = err;
      e.code  = code;
      e.eid   = eid;
      e.buzz  = buzz;
      e.addr  = busOn ? addrTbl[act] : 16'h0;
      e.data  = busOn ? dataTbl[act] : 16'h0;
      e.memEn = busOn ? procMemEnable[act] : 1'b0;
      e.memWr = busOn ? procMemWrite[act] : 1'b0;
      e.gpu   = busOn ? procGpuDraw[act] : 1'b0;
      expQ.push_back(e);
   endtask

   // Let the combinational mux settle, then pop and compare every field
   task automatic checkOutput(input string step);
      exp_t e;
      #1;
      checks++;
      if (expQ.size() == 0) begin
         errors++;
         $display("[TB] FAIL %s.queue observed=empty expected=entry", step);
         return;
      end
      e = expQ.pop_front();
      cmp({step, ".en"},    32'(procEnable), 32'(e.en));
      cmp({step, ".act"},   32'(activeId),   32'(e.act));
      cmp({step, ".err"},   32'(error),      32'(e.err));
      cmp({step, ".led"},   32'(outLed),     32'(e.err));
      cmp({step, ".code"},  32'(errorCode),  32'(e.code));
      cmp({step, ".eid"},   32'(errorId),    32'(e.eid));
      cmp({step, ".buzz"},  32'(outBuzzer),  32'(e.buzz));
      cmp({step, ".addr"},  32'(memAddr),    32'(e.addr));
      cmp({step, ".data"},  32'(memDataw),   32'(e.data));
      cmp({step, ".memEn"}, 32'(memEnable),  32'(e.memEn));
      cmp({step, ".memWr"}, 32'(memWrite),   32'(e.memWr));
      cmp({step, ".gpu"},   32'(gpuDraw),    32'(e.gpu));
   endtask

   initial begin
      addrTbl[0] = 16'h1234; addrTbl[1] = 16'h1111; addrTbl[2] = 16'h5678;
      dataTbl[0] = 16'hBEEF; dataTbl[1] = 16'h2222; dataTbl[2] = 16'hCAFE;
      procMemAddr      = {addrTbl[2], addrTbl[1], addrTbl[0]};
      procMemDataw     = {dataTbl[2], dataTbl[1], dataTbl[0]};
      procSwitchReq    = '0;
      procSwitchTarget = '0;
      procFatal        = '0;
      procMemEnable    = 3'b111;
      procMemWrite     = 3'b101;
      procGpuDraw      = 3'b110;
      procIack         = '0;
      procIend         = '0;

      // Reset and boot
      repeat (2) tick();
      applyStimulus(3'b000, 2'd0, 0, 2'd0, 2'd0, 0); checkOutput("reset");
      rst = 1'b0;
      tick(); applyStimulus(3'b000, 2'd0, 0, 2'd0, 2'd0, 0); checkOutput("boot");
      tick(); applyStimulus(3'b001, 2'd0, 0, 2'd0, 2'd0, 0); checkOutput("run0");

      // Switch 0 -> 2 with a two-cycle handover; the request stays high
      procSwitchReq = 3'b001;
      procSwitchTarget[0*IW +: IW] = 2'd2;
      applyStimulus(3'b001, 2'd0, 0, 2'd0, 2'd0, 0); checkOutput("swReq");
      tick(); applyStimulus(3'b000, 2'd0, 0, 2'd0, 2'd0, 0); checkOutput("ho1");
      tick(); applyStimulus(3'b000, 2'd0, 0, 2'd0, 2'd0, 0); checkOutput("ho2");
      tick(); applyStimulus(3'b100, 2'd2, 0, 2'd0, 2'd0, 0); checkOutput("run2");
      tick(); applyStimulus(3'b100, 2'd2, 0, 2'd0, 2'd0, 0); checkOutput("run2held");
      procSwitchReq = '0;

      // Inactive processor's fatal and request are ignored
      procFatal = 3'b010;
      procSwitchReq = 3'b010;
      procSwitchTarget[1*IW +: IW] = 2'd0;
      tick(); applyStimulus(3'b100, 2'd2, 0, 2'd0, 2'd0, 0); checkOutput("ignore1");
      tick(); applyStimulus(3'b100, 2'd2, 0, 2'd0, 2'd0, 0); checkOutput("ignore2");
      procFatal = '0;

      // Owner requests itself: no change
      procSwitchReq = 3'b100;
      procSwitchTarget[2*IW +: IW] = 2'd2;
      tick(); applyStimulus(3'b100, 2'd2, 0, 2'd0, 2'd0, 0); checkOutput("selfTgt");
      procSwitchReq = '0;

      // mem_enable pulsed every 4 cycles keeps the watchdog quiet
      for (int k = 0; k < 12; k++) begin
         procMemEnable = (k % 4 == 0) ? 3'b111 : 3'b000;
         tick(); applyStimulus(3'b100, 2'd2, 0, 2'd0, 2'd0, 0); checkOutput("wdtPulse");
      end

      // Switch 2 -> 1 with mem_enable idle: watchdog fires 5 cycles after RUN entry
      procMemEnable = 3'b000;
      procSwitchReq = 3'b100;
      procSwitchTarget[2*IW +: IW] = 2'd1;
      tick(); applyStimulus(3'b000, 2'd2, 0, 2'd0, 2'd0, 0); checkOutput("ho1b");
      procSwitchReq = '0;
      tick(); applyStimulus(3'b000, 2'd2, 0, 2'd0, 2'd0, 0); checkOutput("ho2b");
      tick(); applyStimulus(3'b010, 2'd1, 0, 2'd0, 2'd0, 0); checkOutput("wdtEntry");
      for (int i = 1; i < 5; i++) begin
         tick(); applyStimulus(3'b010, 2'd1, 0, 2'd0, 2'd0, 0); checkOutput("wdtIdle");
      end
      tick(); applyStimulus(3'b000, 2'd1, 1, 2'd3, 2'd1, 0); checkOutput("wdtFault");

      // Buzzer toggles every 4 cycles; a fatal during FAULT changes nothing
      procFatal = 3'b010;
      for (int j = 1; j <= 8; j++) begin
         tick();
         applyStimulus(3'b000, 2'd1, 1, 2'd3, 2'd1, (j >= 4 && j < 8) ? 1'b1 : 1'b0);
         checkOutput("buzz");
      end

      // Asynchronous reset out of FAULT
      rst = 1'b1;
      applyStimulus(3'b000, 2'd0, 0, 2'd0, 2'd0, 0); checkOutput("rstFault");
      rst = 1'b0;
      procFatal = '0;
      procMemEnable = 3'b111;
      tick(); applyStimulus(3'b000, 2'd0, 0, 2'd0, 2'd0, 0); checkOutput("boot2");
      tick(); applyStimulus(3'b001, 2'd0, 0, 2'd0, 2'd0, 0); checkOutput("run0b");

      // Target beyond NUM_PROC is a fault with code 2
      procSwitchReq = 3'b001;
      procSwitchTarget[0*IW +: IW] = 2'd3;
      tick(); applyStimulus(3'b000, 2'd0, 1, 2'd2, 2'd0, 0); checkOutput("badTgt");
      procSwitchReq = '0;
      tick(); applyStimulus(3'b000, 2'd0, 1, 2'd2, 2'd0, 0); checkOutput("badTgtSticky");

      // Reset, then reset again in the middle of a handover
      rst = 1'b1; #2; rst = 1'b0;
      tick(); applyStimulus(3'b000, 2'd0, 0, 2'd0, 2'd0, 0); checkOutput("boot3");
      tick(); applyStimulus(3'b001, 2'd0, 0, 2'd0, 2'd0, 0); checkOutput("run0c");
      procSwitchReq = 3'b001;
      procSwitchTarget[0*IW +: IW] = 2'd2;
      tick(); applyStimulus(3'b000, 2'd0, 0, 2'd0, 2'd0, 0); checkOutput("hoMid");
      rst = 1'b1;
      applyStimulus(3'b000, 2'd0, 0, 2'd0, 2'd0, 0); checkOutput("rstHo");
      rst = 1'b0;
      procSwitchReq = '0;
      tick(); applyStimulus(3'b000, 2'd0, 0, 2'd0, 2'd0, 0); checkOutput("boot4");
      tick(); applyStimulus(3'b001, 2'd0, 0, 2'd0, 2'd0, 0); checkOutput("run0d");

      // Switch 0 -> 1, then fatal and a valid request together: fatal wins
      procSwitchReq = 3'b001;
      procSwitchTarget[0*IW +: IW] = 2'd1;
      tick(); applyStimulus(3'b000, 2'd0, 0, 2'd0, 2'd0, 0); checkOutput("ho1c");
      procSwitchReq = '0;
      tick(); applyStimulus(3'b000, 2'd0, 0, 2'd0, 2'd0, 0); checkOutput("ho2c");
      tick(); applyStimulus(3'b010, 2'd1, 0, 2'd0, 2'd0, 0); checkOutput("run1");
      procFatal = 3'b010;
      procSwitchReq = 3'b010;
      procSwitchTarget[1*IW +: IW] = 2'd2;
      tick(); applyStimulus(3'b000, 2'd1, 1, 2'd1, 2'd1, 0); checkOutput("fatalWins");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
